gray_counter: RTL and testbench
===============================

GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning counter width in bits (legal range 2..16).
REQ-002 SHALL have port clk  input  1  rising-edge clock; the only clock.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port en  input  1  count enable; one step per cycle while high.
REQ-005 SHALL have port up  input  1  direction; 1 = increment, 0 = decrement.
REQ-006 SHALL have port load  input  1  synchronous load strobe.
REQ-007 SHALL have port load_bin  input  WIDTH  binary value to load.
REQ-008 SHALL have port bin  output  WIDTH  registered binary count.
REQ-009 SHALL have port gray  output  WIDTH  registered Gray encoding of bin.
REQ-010 SHALL have port wrap  output  1  registered one-cycle pulse on count wrap-around.

Function
REQ-011 SHALL hold the count as a WIDTH-bit binary register; gray SHALL always equal bin ^ (bin >> 1), registered in the same cycle as bin and never combinationally derived at the output.
REQ-012 SHALL apply priority per rising edge: reset > load > en > hold.
REQ-013 SHALL, on load=1, set bin=load_bin and gray=Gray(load_bin) at the next edge, with wrap=0, regardless of en and up.
REQ-014 SHALL, on en=1 and load=0, set bin=bin+1 (up=1) or bin-1 (up=0) modulo 2^WIDTH at the next edge; latency 1 cycle.
REQ-015 SHALL, on en=0 and load=0, hold bin and gray unchanged, with wrap=0.
REQ-016 SHALL assert wrap for exactly the cycle following a step from all-ones to zero (up=1) or from zero to all-ones (up=0); otherwise wrap=0.
REQ-017 SHALL change exactly one gray bit per counting step, including across wrap-around.
REQ-018 SHALL allow up to change on any cycle; the step SHALL use the up value sampled at that edge.
REQ-019 SHALL produce no X on outputs after the first reset edge for any legal input.

Reset
REQ-020 SHALL, when rst_n=0 at a rising edge, set bin=0, gray=0, wrap=0, overriding load and en.
REQ-021 SHALL, on reset asserted mid-count, discard the count; counting SHALL resume from 0 at the first edge with rst_n=1 and en=1.
REQ-022 SHALL NOT respond to rst_n between clock edges.

Configuration
REQ-023 SHALL support macro GRAY_CNT_SAT_EN.
REQ-024 SHALL, with GRAY_CNT_SAT_EN undefined, wrap modulo 2^WIDTH per REQ-014/REQ-016.
REQ-025 SHALL, with GRAY_CNT_SAT_EN defined, saturate: an up-step at all-ones and a down-step at zero SHALL hold the count, and wrap SHALL be tied to 0; load and reset behaviour SHALL be unchanged.

Verification (WIDTH=4)
REQ-026 SHALL cover reset: rst_n=0 for 2 edges with en=1, load=1, load_bin=1010 -> bin=0000, gray=0000, wrap=0.
REQ-027 SHALL cover up-count: en=1, up=1 from 0 for 8 edges -> gray sequence 0001,0011,0010,0110,0111,0101,0100,1100; exactly one bit changes per step.
REQ-028 SHALL cover load priority and wrap: load=1, en=1, load_bin=1111 -> bin=1111, gray=1000, wrap=0; then en=1, up=1 -> bin=0000, gray=0000, wrap=1 for one cycle (with macro: bin=1111, gray=1000, wrap=0).
REQ-029 SHALL cover down wrap: from 0, en=1, up=0 -> bin=1111, gray=1000, wrap=1 (with macro: holds 0000, wrap=0).
REQ-030 SHALL cover hold and mid-count reset: count to 0101, en=0 for 3 edges -> bin stays 0101, gray stays 0111; then rst_n=0 for 1 edge with en=1 -> 0000, then next enabled edge -> bin=0001, gray=0001.

Source files
------------

// File: rtl/gray_counter.sv
// Up/down binary counter with registered Gray-code mirror and wrap pulse.
// Define GRAY_CNT_SAT_EN to saturate at the range ends instead of wrapping (wrap tied low).
module gray_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] gray_q;
  logic             wrap_q;

  logic [WIDTH-1:0] step_bin;
  logic             at_end;
  logic             step_wrap;

  // at_end marks the step that crosses the range boundary in the sampled direction
  always_comb begin
    step_bin  = '0;
    at_end    = 1'b0;
    step_wrap = 1'b0;
    if (up) begin
      at_end   = &bin_q;
      step_bin = bin_q + ONE;
    end else begin
      at_end   = ~|bin_q;
      step_bin = bin_q - ONE;
    end
`ifdef GRAY_CNT_SAT_EN
    if (at_end) begin
      step_bin = bin_q;
    end
    step_wrap = 1'b0;
`else
    step_wrap = at_end;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else if (load) begin
      bin_q  <= load_bin;
      gray_q <= to_gray(load_bin);
      wrap_q <= 1'b0;
    end else if (en) begin
      bin_q  <= step_bin;
      gray_q <= to_gray(step_bin);
      wrap_q <= step_wrap;
    end else begin
      wrap_q <= 1'b0;
    end
  end

  assign bin  = bin_q;
  assign gray = gray_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_gray_counter.sv
// Scoreboard bench for gray_counter (WIDTH=4): directed range/priority cases plus random traffic.
module tb_gray_counter;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst_n, en, up, load;
  logic [W-1:0] load_bin;
  logic [W-1:0] bin, gray;
  logic         wrap;

  always #5 clk = ~clk;

  gray_counter #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_bin (load_bin),
    .bin      (bin),
    .gray     (gray),
    .wrap     (wrap)
  );

  typedef struct packed {
    logic [W-1:0] b;
    logic [W-1:0] g;
    logic         w;
  } exp_t;

  exp_t         sb[$];
  int unsigned  n_vec = 0;
  int unsigned  n_err = 0;
  logic [W-1:0] m_bin = '0;
  logic         m_wrap = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Gray bit i is the XOR of binary bits i and i+1; MSB passes straight through
  function automatic logic [W-1:0] ref_gray(input logic [W-1:0] b);
    logic [W-1:0] g;
    g[W-1] = b[W-1];
    for (int i = 0; i < int'(W) - 1; i++) g[i] = b[i] ^ b[i+1];
    return g;
  endfunction

  task automatic step(input string tag, input logic r, input logic e, input logic u,
                      input logic l, input logic [W-1:0] lb);
    exp_t         x;
    logic [W-1:0] prev_b;
    logic         counted;
    @(negedge clk);
    rst_n = r; en = e; up = u; load = l; load_bin = lb;
    prev_b  = m_bin;
    counted = 1'b0;
    if (!r) begin
      m_bin = '0; m_wrap = 1'b0;
    end else if (l) begin
      m_bin = lb; m_wrap = 1'b0;
    end else if (e) begin
      m_wrap = 1'b0;
      if (u && m_bin == {W{1'b1}}) begin
`ifdef GRAY_CNT_SAT_EN
        m_bin = m_bin;
`else
        m_bin = '0; m_wrap = 1'b1;
`endif
      end else if (!u && m_bin == '0) begin
`ifdef GRAY_CNT_SAT_EN
        m_bin = m_bin;
`else
        m_bin = {W{1'b1}}; m_wrap = 1'b1;
`endif
      end else begin
        m_bin = u ? m_bin + 4'd1 : m_bin - 4'd1;
      end
      counted = (m_bin != prev_b);
    end else begin
      m_wrap = 1'b0;
    end
    sb.push_back('{b: m_bin, g: ref_gray(m_bin), w: m_wrap});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      x = sb.pop_front();
      check({tag, ".bin"},  32'(bin),  32'(x.b));
      check({tag, ".gray"}, 32'(gray), 32'(x.g));
      check({tag, ".wrap"}, 32'(wrap), 32'(x.w));
    end
    if (counted)
      check({tag, ".onebit"}, 32'($countones(gray ^ ref_gray(prev_b))), 32'd1);
    check({tag, ".noX"}, 32'($isunknown({bin, gray, wrap})), 32'd0);
  endtask

  task automatic lit(input string tag, input logic [W-1:0] b, input logic [W-1:0] g, input logic w);
    check({tag, ".lit_bin"},  32'(bin),  32'(b));
    check({tag, ".lit_gray"}, 32'(gray), 32'(g));
    check({tag, ".lit_wrap"}, 32'(wrap), 32'(w));
  endtask

  logic [W-1:0] up_seq [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                               4'b0111, 4'b0101, 4'b0100, 4'b1100};

  initial begin
    rst_n = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_bin = '0;

    step("rst0", 1'b0, 1'b1, 1'b1, 1'b1, 4'b1010);
    step("rst1", 1'b0, 1'b1, 1'b1, 1'b1, 4'b1010);
    lit("rst", 4'b0000, 4'b0000, 1'b0);

    for (int i = 0; i < 8; i++) begin
      step("up", 1'b1, 1'b1, 1'b1, 1'b0, '0);
      check("up_seq", 32'(gray), 32'(up_seq[i]));
    end

    step("load", 1'b1, 1'b1, 1'b1, 1'b1, 4'b1111);
    lit("load", 4'b1111, 4'b1000, 1'b0);
    step("upwrap", 1'b1, 1'b1, 1'b1, 1'b0, '0);
`ifdef GRAY_CNT_SAT_EN
    lit("upwrap", 4'b1111, 4'b1000, 1'b0);
`else
    lit("upwrap", 4'b0000, 4'b0000, 1'b1);
`endif
    step("after_wrap", 1'b1, 1'b0, 1'b1, 1'b0, '0);
    check("wrap_pulse", 32'(wrap), 32'd0);

    step("rst2", 1'b0, 1'b0, 1'b0, 1'b0, '0);
    step("dnwrap", 1'b1, 1'b1, 1'b0, 1'b0, '0);
`ifdef GRAY_CNT_SAT_EN
    lit("dnwrap", 4'b0000, 4'b0000, 1'b0);
`else
    lit("dnwrap", 4'b1111, 4'b1000, 1'b1);
`endif

    step("rst3", 1'b0, 1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 5; i++) step("cnt5", 1'b1, 1'b1, 1'b1, 1'b0, '0);
    lit("cnt5", 4'b0101, 4'b0111, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step("hold", 1'b1, 1'b0, 1'b1, 1'b0, '0);
      lit("hold", 4'b0101, 4'b0111, 1'b0);
    end

    // Reset pulse between edges must not disturb the count
    #1 rst_n = 1'b0;
    #2 lit("rst_glitch", 4'b0101, 4'b0111, 1'b0);
    rst_n = 1'b1;

    step("midrst", 1'b0, 1'b1, 1'b1, 1'b0, '0);
    lit("midrst", 4'b0000, 4'b0000, 1'b0);
    step("resume", 1'b1, 1'b1, 1'b1, 1'b0, '0);
    lit("resume", 4'b0001, 4'b0001, 1'b0);

    for (int i = 0; i < 300; i++)
      step("rand", ($urandom_range(0, 19) != 0), ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), W'($urandom_range(0, 15)));

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
